// File: rtl/bullet_engine.sv
// bullet_engine: per-tank bullet controller (spawn, move, explode, cooldown).
// Ports: clk_i/reset_ni (sync, active-low), frame_tick_i, fire_i, tank_*_i,
// explose_i, pixel_*_i in; bullet/explosion pixel masks, status, position out.
module bullet_engine #(
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int TANK_SIZE       = 16,
  parameter int BULLET_SIZE     = 4,
  parameter int SPEED           = 2,
  parameter int EXPLODE_FRAMES  = 8,
  parameter int COOLDOWN_FRAMES = 16
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       frame_tick_i,
  input  logic       fire_i,
  input  logic [9:0] tank_x_i,
  input  logic [9:0] tank_y_i,
  input  logic [1:0] tank_dir_i,
  input  logic       tank_alive_i,
  input  logic       explose_i,
  input  logic [9:0] pixel_x_i,
  input  logic [9:0] pixel_y_i,
  output logic       bullet_pixel_o,
  output logic       explosion_pixel_o,
  output logic       bullet_active_o,
  output logic       busy_o,
  output logic       fire_ack_o,
  output logic [9:0] bullet_x_o,
  output logic [9:0] bullet_y_o,
  output logic [1:0] bullet_dir_o
);

  localparam int MAXF = (EXPLODE_FRAMES > COOLDOWN_FRAMES) ?
                        EXPLODE_FRAMES : COOLDOWN_FRAMES;
  localparam int CW = $clog2(MAXF + 1);

  localparam logic signed [10:0] L_HALF = 11'((TANK_SIZE - BULLET_SIZE) / 2);
  localparam logic signed [10:0] L_TS   = 11'(TANK_SIZE);
  localparam logic signed [10:0] L_BS   = 11'(BULLET_SIZE);
  localparam logic signed [10:0] L_SPD  = 11'(SPEED);
  localparam logic signed [10:0] L_XMAX = 11'(SCREEN_W - BULLET_SIZE);
  localparam logic signed [10:0] L_YMAX = 11'(SCREEN_H - BULLET_SIZE);
  localparam logic signed [11:0] L_EOFF = 12'(BULLET_SIZE / 2);
  localparam logic signed [11:0] L_EW   = 12'(2 * BULLET_SIZE);
  localparam logic [CW-1:0]      L_ELST = CW'(EXPLODE_FRAMES - 1);
  localparam logic [CW-1:0]      L_CLST = CW'(COOLDOWN_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_FLY, S_EXP, S_COOL
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [9:0]      r_x, r_y, w_x_nxt, w_y_nxt;
  logic [1:0]      r_dir, w_dir_nxt;
  logic            r_ack, w_ack_nxt;
  logic            r_bpix, r_epix;

  logic signed [10:0] w_tx, w_ty, w_bx, w_by;
  logic signed [10:0] w_sx, w_sy, w_mx, w_my;
  logic               w_out;
  logic               w_bhit, w_ehit;
  logic signed [11:0] w_px, w_py, w_ex, w_ey;

  function automatic logic [9:0] clamp(
    input logic signed [10:0] v,
    input logic signed [10:0] hi
  );
    if (v < 0)       return '0;
    else if (v > hi) return hi[9:0];
    else             return v[9:0];
  endfunction

  assign w_tx = signed'({1'b0, tank_x_i});
  assign w_ty = signed'({1'b0, tank_y_i});
  assign w_bx = signed'({1'b0, r_x});
  assign w_by = signed'({1'b0, r_y});

  always_comb begin
    w_sx = w_tx;
    w_sy = w_ty;
    unique case (tank_dir_i)
      2'd0: begin w_sx = w_tx + L_HALF; w_sy = w_ty - L_BS;   end
      2'd1: begin w_sx = w_tx + L_TS;   w_sy = w_ty + L_HALF; end
      2'd2: begin w_sx = w_tx + L_HALF; w_sy = w_ty + L_TS;   end
      2'd3: begin w_sx = w_tx - L_BS;   w_sy = w_ty + L_HALF; end
      default: ;
    endcase
  end

  always_comb begin
    w_mx = w_bx;
    w_my = w_by;
    unique case (r_dir)
      2'd0: w_my = w_by - L_SPD;
      2'd1: w_mx = w_bx + L_SPD;
      2'd2: w_my = w_by + L_SPD;
      2'd3: w_mx = w_bx - L_SPD;
      default: ;
    endcase
  end

  assign w_out = (w_mx < 0) || (w_mx > L_XMAX) ||
                 (w_my < 0) || (w_my > L_YMAX);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_dir_nxt   = r_dir;
    w_ack_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (fire_i && tank_alive_i) begin
          w_state_nxt = S_FLY;
          w_dir_nxt   = tank_dir_i;
          w_x_nxt     = clamp(w_sx, L_XMAX);
          w_y_nxt     = clamp(w_sy, L_YMAX);
          w_ack_nxt   = 1'b1;
        end
      end
      S_FLY: begin
        // a hit freezes the bullet even on a tick cycle
        if (explose_i) begin
          w_state_nxt = S_EXP;
          w_cnt_nxt   = '0;
        end else if (frame_tick_i) begin
          w_x_nxt = clamp(w_mx, L_XMAX);
          w_y_nxt = clamp(w_my, L_YMAX);
          if (w_out) begin
            w_state_nxt = S_EXP;
            w_cnt_nxt   = '0;
          end
        end
      end
      S_EXP: begin
        if (frame_tick_i) begin
          if (r_cnt == L_ELST) begin
            w_state_nxt = S_COOL;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_COOL: begin
        if (frame_tick_i) begin
          if (r_cnt == L_CLST) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_bhit = ({1'b0, pixel_x_i} >= {1'b0, r_x}) &&
                  ({1'b0, pixel_x_i} <  {1'b0, r_x} + L_BS) &&
                  ({1'b0, pixel_y_i} >= {1'b0, r_y}) &&
                  ({1'b0, pixel_y_i} <  {1'b0, r_y} + L_BS);

  // signed so a box hanging off the top/left edge does not wrap
  assign w_px = signed'({2'b0, pixel_x_i});
  assign w_py = signed'({2'b0, pixel_y_i});
  assign w_ex = signed'({2'b0, r_x}) - L_EOFF;
  assign w_ey = signed'({2'b0, r_y}) - L_EOFF;
  assign w_ehit = (w_px >= w_ex) && (w_px < w_ex + L_EW) &&
                  (w_py >= w_ey) && (w_py < w_ey + L_EW);

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_dir   <= '0;
      r_ack   <= 1'b0;
      r_bpix  <= 1'b0;
      r_epix  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_dir   <= w_dir_nxt;
      r_ack   <= w_ack_nxt;
      r_bpix  <= (r_state == S_FLY) && w_bhit;
      r_epix  <= (r_state == S_EXP) && w_ehit;
    end
  end

  assign bullet_pixel_o    = r_bpix;
  assign explosion_pixel_o = r_epix;
  assign bullet_active_o   = (r_state == S_FLY);
  assign busy_o            = (r_state != S_IDLE);
  assign fire_ack_o        = r_ack;
  assign bullet_x_o        = r_x;
  assign bullet_y_o        = r_y;
  assign bullet_dir_o      = r_dir;

endmodule
